// File: rtl/field_array_regblock.sv
`default_nettype none
// ============================================================================
// Module   : field_array_regblock
// Purpose  : Array of N_REGS identical 32-bit CPU-visible registers. Each
//            register holds one FIELD_W-bit field in bits [FIELD_W-1:0].
//            Fields can be written by software and by hardware. Each field
//            exports its value, AND/OR/XOR reductions and a
//            software-modified pulse.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, arst_n          : clock (rising edge) and async active-low reset.
//                          Reset is released synchronously inside the block.
//   s_cpuif_req*         : pipelined CPU request (addr, wr_data, wr_biten).
//   s_cpuif_req_stall_*  : always 0; a request is accepted every cycle.
//   s_cpuif_rd_*         : read ack, read err and read data, 1 cycle after
//                          the request.
//   s_cpuif_wr_*         : write ack and write err, 1 cycle after the request.
//   hwif_in_we/next      : per-register hardware write enable and value.
//                          Register i uses slice [i*FIELD_W +: FIELD_W].
//   hwif_out_value       : field values, packed the same way.
//   hwif_out_anded/ored/xored : per-field reductions (combinational).
//   hwif_out_swmod       : 1-cycle pulse after a software write to a field.
// Configuration
//   FIELD_ARRAY_REGBLOCK_ERR_EN : when defined, an access to an out-of-range
//                                 or misaligned address returns err=1 with
//                                 the ack. When undefined, err is tied to 0.
// ============================================================================
module field_array_regblock #(
  parameter int               N_REGS    = 112,
  parameter int               FIELD_W   = 8,
  parameter int               ADDR_W    = 9,
  parameter logic [FIELD_W-1:0] RESET_VAL = '0
) (
  input  logic                        clk,
  input  logic                        arst_n,
  input  logic                        s_cpuif_req,
  input  logic                        s_cpuif_req_is_wr,
  input  logic [ADDR_W-1:0]           s_cpuif_addr,
  input  logic [31:0]                 s_cpuif_wr_data,
  input  logic [31:0]                 s_cpuif_wr_biten,
  output logic                        s_cpuif_req_stall_wr,
  output logic                        s_cpuif_req_stall_rd,
  output logic                        s_cpuif_rd_ack,
  output logic                        s_cpuif_rd_err,
  output logic [31:0]                 s_cpuif_rd_data,
  output logic                        s_cpuif_wr_ack,
  output logic                        s_cpuif_wr_err,
  input  logic [N_REGS-1:0]           hwif_in_we,
  input  logic [N_REGS*FIELD_W-1:0]   hwif_in_next,
  output logic [N_REGS*FIELD_W-1:0]   hwif_out_value,
  output logic [N_REGS-1:0]           hwif_out_anded,
  output logic [N_REGS-1:0]           hwif_out_ored,
  output logic [N_REGS-1:0]           hwif_out_xored,
  output logic [N_REGS-1:0]           hwif_out_swmod
);

  localparam int IDX_W = ADDR_W - 2;

  // Assertion of arst_n is asynchronous. Release is retimed through two
  // flops, so every state flop leaves reset on a clean clock edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) rst_sync <= 2'b00;
    else         rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign s_cpuif_req_stall_wr = 1'b0;
  assign s_cpuif_req_stall_rd = 1'b0;

  // Address decode
  logic [IDX_W-1:0]   idx;
  logic               addr_ok;
  logic               wr_fire;
  logic               rd_req;
  logic               wr_req;
  logic [FIELD_W-1:0] wr_data_f;
  logic [FIELD_W-1:0] wr_be_f;

  assign idx       = s_cpuif_addr[ADDR_W-1:2];
  assign addr_ok   = (s_cpuif_addr[1:0] == 2'b00) && (32'(idx) < N_REGS);
  assign rd_req    = s_cpuif_req & ~s_cpuif_req_is_wr;
  assign wr_req    = s_cpuif_req &  s_cpuif_req_is_wr;
  assign wr_fire   = wr_req & addr_ok;
  assign wr_data_f = s_cpuif_wr_data[FIELD_W-1:0];
  assign wr_be_f   = s_cpuif_wr_biten[FIELD_W-1:0];

  // Only the low FIELD_W bits of the write bus reach a field.
  logic unused_wr_bits;
  assign unused_wr_bits = &{1'b0, s_cpuif_wr_data, s_cpuif_wr_biten};

  // Field storage
  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    logic [FIELD_W-1:0] q;
    logic               swmod_q;
    logic               sw_hit;

    assign sw_hit = wr_fire & (idx == IDX_W'(i));

    // A software write overrides a hardware write in the same cycle,
    // including the bits that biten masks off.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q       <= RESET_VAL;
        swmod_q <= 1'b0;
      end else begin
        if (sw_hit)
          q <= (q & ~wr_be_f) | (wr_data_f & wr_be_f);
        else if (hwif_in_we[i])
          q <= hwif_in_next[i*FIELD_W +: FIELD_W];
        swmod_q <= sw_hit & (|wr_be_f);
      end
    end

    assign hwif_out_value[i*FIELD_W +: FIELD_W] = q;
    assign hwif_out_anded[i] = &q;
    assign hwif_out_ored[i]  = |q;
    assign hwif_out_xored[i] = ^q;
    assign hwif_out_swmod[i] = swmod_q;
  end

  // Read mux. It reads the field values from before the current cycle's
  // writes, so a same-cycle hardware write does not appear in the read data.
  logic [FIELD_W-1:0] rd_field;
  logic [31:0]        rd_word;

  always_comb begin
    rd_field = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (32'(idx) == i) rd_field = hwif_out_value[i*FIELD_W +: FIELD_W];
    end
    rd_word = '0;
    rd_word[FIELD_W-1:0] = rd_field;
  end

  // Response stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cpuif_rd_ack  <= 1'b0;
      s_cpuif_wr_ack  <= 1'b0;
      s_cpuif_rd_data <= '0;
    end else begin
      s_cpuif_rd_ack  <= rd_req;
      s_cpuif_wr_ack  <= wr_req;
      s_cpuif_rd_data <= (rd_req && addr_ok) ? rd_word : 32'h0;
    end
  end

`ifdef FIELD_ARRAY_REGBLOCK_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_cpuif_rd_err <= 1'b0;
      s_cpuif_wr_err <= 1'b0;
    end else begin
      s_cpuif_rd_err <= rd_req & ~addr_ok;
      s_cpuif_wr_err <= wr_req & ~addr_ok;
    end
  end
`else
  assign s_cpuif_rd_err = 1'b0;
  assign s_cpuif_wr_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_field_array_regblock.sv
`default_nettype none
// ============================================================================
// Module   : tb_field_array_regblock
// Purpose  : Scoreboard testbench for field_array_regblock. The stimulus
//            pushes hand-computed responses into a queue. A monitor on the
//            falling edge pops the queue and compares each ack it sees.
//            Two small instances check the FIELD_W=32 and FIELD_W=1
//            reductions.
// Revision : 1.0 - initial release
// ============================================================================
module tb_field_array_regblock;

  localparam int N  = 112;
  localparam int FW = 8;
  localparam int AW = 9;
`ifdef FIELD_ARRAY_REGBLOCK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic            req = 0, is_wr = 0;
  logic [AW-1:0]   addr = '0;
  logic [31:0]     wdata = '0, biten = '0;
  logic [N-1:0]    hw_we = '0;
  logic [N*FW-1:0] hw_next = '0;
  logic            stall_wr, stall_rd, rd_ack, rd_err, wr_ack, wr_err;
  logic [31:0]     rd_data;
  logic [N*FW-1:0] value;
  logic [N-1:0]    anded, ored, xored, swmod;

  field_array_regblock #(.N_REGS(N), .FIELD_W(FW), .ADDR_W(AW), .RESET_VAL(8'h00)) dut (
    .clk(clk), .arst_n(arst_n),
    .s_cpuif_req(req), .s_cpuif_req_is_wr(is_wr), .s_cpuif_addr(addr),
    .s_cpuif_wr_data(wdata), .s_cpuif_wr_biten(biten),
    .s_cpuif_req_stall_wr(stall_wr), .s_cpuif_req_stall_rd(stall_rd),
    .s_cpuif_rd_ack(rd_ack), .s_cpuif_rd_err(rd_err), .s_cpuif_rd_data(rd_data),
    .s_cpuif_wr_ack(wr_ack), .s_cpuif_wr_err(wr_err),
    .hwif_in_we(hw_we), .hwif_in_next(hw_next),
    .hwif_out_value(value), .hwif_out_anded(anded), .hwif_out_ored(ored),
    .hwif_out_xored(xored), .hwif_out_swmod(swmod)
  );

  // Small parametrisations: N_REGS=4 with FIELD_W=32 and with FIELD_W=1
  logic         p_req = 0, p_wr = 0;
  logic [3:0]   p_addr = '0;
  logic [31:0]  p_wdata = '0, p_be = '0;
  logic         a_sw, a_sr, a_ra, a_re, a_wa, a_we;
  logic [31:0]  a_rd;
  logic [127:0] a_val;
  logic [3:0]   a_and, a_or, a_xor, a_sm;
  logic         b_sw, b_sr, b_ra, b_re, b_wa, b_we;
  logic [31:0]  b_rd;
  logic [3:0]   b_val, b_and, b_or, b_xor, b_sm;

  field_array_regblock #(.N_REGS(4), .FIELD_W(32), .ADDR_W(4), .RESET_VAL(32'h0)) u_w32 (
    .clk(clk), .arst_n(arst_n),
    .s_cpuif_req(p_req), .s_cpuif_req_is_wr(p_wr), .s_cpuif_addr(p_addr),
    .s_cpuif_wr_data(p_wdata), .s_cpuif_wr_biten(p_be),
    .s_cpuif_req_stall_wr(a_sw), .s_cpuif_req_stall_rd(a_sr),
    .s_cpuif_rd_ack(a_ra), .s_cpuif_rd_err(a_re), .s_cpuif_rd_data(a_rd),
    .s_cpuif_wr_ack(a_wa), .s_cpuif_wr_err(a_we),
    .hwif_in_we(4'b0), .hwif_in_next(128'h0),
    .hwif_out_value(a_val), .hwif_out_anded(a_and), .hwif_out_ored(a_or),
    .hwif_out_xored(a_xor), .hwif_out_swmod(a_sm)
  );

  field_array_regblock #(.N_REGS(4), .FIELD_W(1), .ADDR_W(4), .RESET_VAL(1'b0)) u_w1 (
    .clk(clk), .arst_n(arst_n),
    .s_cpuif_req(p_req), .s_cpuif_req_is_wr(p_wr), .s_cpuif_addr(p_addr),
    .s_cpuif_wr_data(p_wdata), .s_cpuif_wr_biten(p_be),
    .s_cpuif_req_stall_wr(b_sw), .s_cpuif_req_stall_rd(b_sr),
    .s_cpuif_rd_ack(b_ra), .s_cpuif_rd_err(b_re), .s_cpuif_rd_data(b_rd),
    .s_cpuif_wr_ack(b_wa), .s_cpuif_wr_err(b_we),
    .hwif_in_we(4'b0), .hwif_in_next(4'h0),
    .hwif_out_value(b_val), .hwif_out_anded(b_and), .hwif_out_ored(b_or),
    .hwif_out_xored(b_xor), .hwif_out_swmod(b_sm)
  );

  typedef struct {
    bit          is_wr;
    bit          err;
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [FW-1:0] val(input int i);
    return value[i*FW +: FW];
  endfunction

  // Monitor: pops one expected response per ack and checks its cycle,
  // type, err and data. A response that is still queued after its due
  // cycle counts as missed.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      exp_t m;
      m = sb.pop_front();
      check("missed_ack_due_cycle", 32'(cyc), 32'(m.due));
    end
    if (rd_ack || wr_ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", {30'b0, rd_ack, wr_ack}, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("ack_cycle", 32'(cyc), 32'(e.due));
        check("ack_is_wr", {31'b0, wr_ack}, {31'b0, e.is_wr});
        if (e.is_wr) begin
          check("wr_err", {31'b0, wr_err}, {31'b0, e.err});
        end else begin
          check("rd_err", {31'b0, rd_err}, {31'b0, e.err});
          check("rd_data", rd_data, e.data);
        end
      end
    end else begin
      check("rd_data_idle_zero", rd_data, 32'h0);
    end
  end

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] be,
                        input bit bad);
    exp_t e;
    req = 1; is_wr = 1; addr = a; wdata = d; biten = be;
    e.is_wr = 1; e.err = ERR_EN & bad; e.data = 32'h0; e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 0; is_wr = 0;
  endtask

  task automatic cpu_rd(input logic [AW-1:0] a, input logic [31:0] exp_d, input bit bad);
    exp_t e;
    req = 1; is_wr = 0; addr = a;
    e.is_wr = 0; e.err = ERR_EN & bad; e.data = exp_d; e.due = cyc + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 arst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    check("stall_wr", {31'b0, stall_wr}, 32'h0);
    check("stall_rd", {31'b0, stall_rd}, 32'h0);

    // Put a nonzero value in a field so the reset check has something to clear
    cpu_wr(9'd28, 32'h33, 32'hFF, 0);
    check("pre_reset_val7", 32'(val(7)), 32'h33);
    idle();

    // Assert reset while a read is being sampled. No ack may follow.
    req = 1; is_wr = 0; addr = 9'd28;
    #2 arst_n = 0;
    @(posedge clk); #1 req = 0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_value_any", 32'(|value), 32'h0);
    check("reset_anded", 32'(|anded), 32'h0);
    check("reset_ored", 32'(|ored), 32'h0);
    check("reset_xored", 32'(|xored), 32'h0);
    check("reset_swmod", 32'(|swmod), 32'h0);

    // Partial-biten write to reg 5
    cpu_wr(9'd20, 32'hFF, 32'h0F, 0);
    check("val5_after_write", 32'(val(5)), 32'h0F);
    check("swmod5_pulse", 32'(swmod[5]), 32'h1);
    idle();
    check("swmod5_cleared", 32'(swmod[5]), 32'h0);
    cpu_rd(9'd20, 32'h0000000F, 0);
    check("anded5", 32'(anded[5]), 32'h0);
    check("ored5", 32'(ored[5]), 32'h1);
    check("xored5", 32'(xored[5]), 32'h0);

    // Write that only enables bits above the field: no change, no swmod
    cpu_wr(9'd20, 32'hFFFFFF00, 32'hFFFFFF00, 0);
    check("val5_upper_only", 32'(val(5)), 32'h0F);
    check("swmod5_upper_only", 32'(swmod[5]), 32'h0);

    // Same-cycle software and hardware write to reg 3: software wins
    hw_we[3] = 1; hw_next[3*FW +: FW] = 8'h55;
    cpu_wr(9'd12, 32'hAA, 32'hFF, 0);
    hw_we[3] = 0;
    check("val3_sw_wins", 32'(val(3)), 32'hAA);
    check("swmod3_sw", 32'(swmod[3]), 32'h1);
    hw_we[3] = 1; hw_next[3*FW +: FW] = 8'h55;
    idle();
    hw_we[3] = 0;
    check("val3_hw_only", 32'(val(3)), 32'h55);
    check("swmod3_hw_only", 32'(swmod[3]), 32'h0);

    // A read returns the value from before a same-cycle hardware write
    hw_we[3] = 1; hw_next[3*FW +: FW] = 8'h11;
    cpu_rd(9'd12, 32'h55, 0);
    hw_we[3] = 0;
    check("val3_after_hw", 32'(val(3)), 32'h11);

    // Back-to-back accesses to the last register
    cpu_wr(9'd444, 32'hFF, 32'hFF, 0);
    cpu_rd(9'd444, 32'hFF, 0);
    check("anded111", 32'(anded[111]), 32'h1);
    check("xored111", 32'(xored[111]), 32'h0);

    // Pipelined reads of three registers
    cpu_rd(9'd12, 32'h11, 0);
    cpu_rd(9'd20, 32'h0F, 0);
    cpu_rd(9'd444, 32'hFF, 0);

    // Invalid addresses: out of range, misaligned write, misaligned read
    cpu_rd(9'd448, 32'h0, 1);
    cpu_wr(9'h006, 32'hFF, 32'hFF, 1);
    check("val1_untouched", 32'(val(1)), 32'h0);
    check("swmod_none_invalid", 32'(|swmod), 32'h0);
    cpu_rd(9'h016, 32'h0, 1);
    check("val5_untouched", 32'(val(5)), 32'h0F);

    // Small instances: write all ones to reg 1
    p_req = 1; p_wr = 1; p_addr = 4'h4; p_wdata = 32'hFFFFFFFF; p_be = 32'hFFFFFFFF;
    @(posedge clk); #1;
    p_req = 0; p_wr = 0;
    check("w32_val1", a_val[63:32], 32'hFFFFFFFF);
    check("w32_anded1", 32'(a_and[1]), 32'h1);
    check("w32_xored1", 32'(a_xor[1]), 32'h0);
    check("w1_anded1", 32'(b_and[1]), 32'h1);
    check("w1_ored1", 32'(b_or[1]), 32'h1);
    check("w1_xored1", 32'(b_xor[1]), 32'h1);

    idle();
    idle();
    check("scoreboard_drained", 32'(sb.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
